// File: rtl/iq_point_source.sv
// iq_point_source: programmable signed (I,Q) sweep source for hist2d bring-up.
// Optional: define IQ_SRC_DITHER_EN to add LFSR dither to emitted points.
// Ports:
//   clk100, rst_n (sync, active low)
//   start, abort : sweep control
//   i_start/q_start, i_step/q_step, num_data_pts, gap_cycles,
//   ack_mode, ack_timeout : sweep config, latched on accepted start
//   bin_found : ack from hist2d
//   data_in, i_val/q_val : point strobe and value
//   busy, done, pts_sent, timeout_err : status
module iq_point_source #(
  parameter int VAL_W  = 32,
  parameter int STEP_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [VAL_W-1:0]  i_start,
  input  logic [VAL_W-1:0]  q_start,
  input  logic [STEP_W-1:0] i_step,
  input  logic [STEP_W-1:0] q_step,
  input  logic [CNT_W-1:0]  num_data_pts,
  input  logic [CNT_W-1:0]  gap_cycles,
  input  logic              ack_mode,
  input  logic [CNT_W-1:0]  ack_timeout,
  input  logic              bin_found,
  output logic              data_in,
  output logic [VAL_W-1:0]  i_val,
  output logic [VAL_W-1:0]  q_val,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pts_sent,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state, state_nxt;

  logic [CNT_W-1:0] num_r, gap_r, tmo_r, cnt;
  logic             ack_r;
  logic [VAL_W-1:0] i_stp, q_stp;
  logic [VAL_W-1:0] i_ramp, q_ramp;
  logic [VAL_W-1:0] i_ramp_nxt, q_ramp_nxt;
  logic [VAL_W-1:0] i_dith, q_dith;
  logic             accept, inc_pts, set_to, emit;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    inc_pts   = 1'b0;
    set_to    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (num_data_pts == '0) ? S_DONE : S_EMIT;
        end
      end
      S_EMIT: begin
        inc_pts = 1'b1;
        // an ack arriving with the strobe itself skips the wait
        state_nxt = (ack_r && !bin_found) ? S_WAIT : S_GAP;
      end
      S_WAIT: begin
        if (bin_found) begin
          state_nxt = S_GAP;
        end else if (tmo_r != '0 && cnt == tmo_r) begin
          set_to    = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt >= gap_r)
          state_nxt = (pts_sent == num_r) ? S_DONE : S_EMIT;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      accept    = 1'b0;
      inc_pts   = 1'b0;
      set_to    = 1'b0;
    end
  end

  assign emit = (state_nxt == S_EMIT);

  assign i_ramp_nxt = accept ? i_start : i_ramp + i_stp;
  assign q_ramp_nxt = accept ? q_start : q_ramp + q_stp;

`ifdef IQ_SRC_DITHER_EN
  localparam logic [15:0] SEED = 16'hACE1;

  logic [15:0] lfsr, lfsr_cur;

  // a fresh sweep dithers from the seed, not the stale register
  assign lfsr_cur = accept ? SEED : lfsr;
  assign i_dith = {{(VAL_W-4){lfsr_cur[3]}}, lfsr_cur[3:0]};
  assign q_dith = {{(VAL_W-4){lfsr_cur[7]}}, lfsr_cur[7:4]};

  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (emit) begin
      lfsr <= {lfsr_cur[14:0],
               lfsr_cur[15] ^ lfsr_cur[13] ^
               lfsr_cur[12] ^ lfsr_cur[10]};
    end else if (accept) begin
      lfsr <= SEED;
    end
  end
`else
  assign i_dith = '0;
  assign q_dith = '0;
`endif

  always_ff @(posedge clk100) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      data_in     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      i_val       <= '0;
      q_val       <= '0;
      pts_sent    <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      num_r       <= '0;
      gap_r       <= '0;
      tmo_r       <= '0;
      ack_r       <= 1'b0;
      i_stp       <= '0;
      q_stp       <= '0;
      i_ramp      <= '0;
      q_ramp      <= '0;
    end else begin
      data_in <= emit;
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_DONE);
      // wait/gap timer restarts at 1 on every state change
      cnt     <= (state_nxt != state) ? ONE : cnt + ONE;
      if (accept) begin
        num_r       <= num_data_pts;
        gap_r       <= (gap_cycles == '0) ? ONE : gap_cycles;
        tmo_r       <= ack_timeout;
        ack_r       <= ack_mode;
        i_stp       <= {{(VAL_W-STEP_W){i_step[STEP_W-1]}}, i_step};
        q_stp       <= {{(VAL_W-STEP_W){q_step[STEP_W-1]}}, q_step};
        pts_sent    <= '0;
        timeout_err <= 1'b0;
      end
      if (inc_pts) pts_sent    <= pts_sent + ONE;
      if (set_to)  timeout_err <= 1'b1;
      if (emit) begin
        i_ramp <= i_ramp_nxt;
        q_ramp <= q_ramp_nxt;
        i_val  <= i_ramp_nxt + i_dith;
        q_val  <= q_ramp_nxt + q_dith;
      end
    end
  end

endmodule

// File: tb/tb_iq_point_source.sv
// tb_iq_point_source: scenario tasks against an arithmetic sweep model.
// Pulses and done strobes are time-stamped by a negedge monitor.
module tb_iq_point_source;

  logic        clk100 = 1'b0;
  logic        rst_n, start, abort, ack_mode, bin_found;
  logic [31:0] i_start, q_start;
  logic [15:0] i_step, q_step, num_data_pts, gap_cycles, ack_timeout;
  logic        data_in, busy, done, timeout_err;
  logic [31:0] i_val, q_val;
  logic [15:0] pts_sent;

  iq_point_source dut (
    .clk100       (clk100),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .i_start      (i_start),
    .q_start      (q_start),
    .i_step       (i_step),
    .q_step       (q_step),
    .num_data_pts (num_data_pts),
    .gap_cycles   (gap_cycles),
    .ack_mode     (ack_mode),
    .ack_timeout  (ack_timeout),
    .bin_found    (bin_found),
    .data_in      (data_in),
    .i_val        (i_val),
    .q_val        (q_val),
    .busy         (busy),
    .done         (done),
    .pts_sent     (pts_sent),
    .timeout_err  (timeout_err)
  );

  always #5 clk100 = ~clk100;

  int cyc = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  int          pt_t[$];
  logic [31:0] pt_i[$];
  logic [31:0] pt_q[$];
  int          done_t[$];
  int          b2b = 0;
  logic        prev_din = 1'b0;

  always @(negedge clk100) begin
    if (data_in === 1'b1) begin
      pt_t.push_back(cyc);
      pt_i.push_back(i_val);
      pt_q.push_back(q_val);
    end
    if (done === 1'b1) done_t.push_back(cyc);
    if (data_in === 1'b1 && prev_din) b2b++;
    prev_din = (data_in === 1'b1);
  end

  int checks = 0;
  int errors = 0;
  int t0, p0, d0;
  bit hung;

  function automatic logic [31:0] ramp_at(logic [31:0] s,
                                          logic [15:0] stp, int k);
    return s + 32'(k) * {{16{stp[15]}}, stp};
  endfunction

  function automatic int period(logic [15:0] g, int wait_c);
    return 1 + wait_c + ((g == 16'd0) ? 1 : int'(g));
  endfunction

  task automatic run_sweep(input logic [31:0] si, input logic [31:0] sq,
                           input logic [15:0] ti, input logic [15:0] tq,
                           input logic [15:0] n, input logic [15:0] g,
                           input logic am, input logic [15:0] tmo,
                           input int ackd, input int budget);
    int cd;
    @(negedge clk100);
    i_start = si; q_start = sq; i_step = ti; q_step = tq;
    num_data_pts = n; gap_cycles = g;
    ack_mode = am; ack_timeout = tmo;
    p0 = pt_t.size(); d0 = done_t.size();
    start = 1'b1; t0 = cyc;
    @(negedge clk100);
    start = (n != 16'd0);
    i_start = $urandom; q_start = $urandom;
    i_step = 16'($urandom); q_step = 16'($urandom);
    num_data_pts = 16'($urandom); gap_cycles = 16'($urandom);
    ack_mode = 1'($urandom); ack_timeout = 16'($urandom);
    cd = -1; hung = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (c == 1) start = 1'b0;
      bin_found = 1'b0;
      if (cd > 0) cd--;
      if (cd == 0) begin bin_found = 1'b1; cd = -1; end
      if (data_in === 1'b1 && ackd >= 0) begin
        if (ackd == 0) bin_found = 1'b1;
        else cd = ackd;
      end
      if (done === 1'b1) begin hung = 1'b0; break; end
      @(negedge clk100);
    end
    start = 1'b0;
    bin_found = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    ack_mode = 1'b0; bin_found = 1'b0;
    i_start = '0; q_start = '0; i_step = '0; q_step = '0;
    num_data_pts = '0; gap_cycles = '0; ack_timeout = '0;
    repeat (2) @(posedge clk100);
    @(negedge clk100);
    checks++;
    if ({data_in, busy, done, timeout_err, pts_sent, i_val, q_val} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: din=%b busy=%b done=%b to=%b pts=%0d i=%h q=%h, need all 0",
               data_in, busy, done, timeout_err, pts_sent, i_val, q_val);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ramp;
    logic [31:0] si, sq;
    logic [15:0] ti, tq, n, g;
    int p;
    for (int r = 0; r < 6; r++) begin
      case (r)
        0: begin
          si = 32'hFFFF_FFFD; sq = 32'hFFFF_FFFD;
          ti = 16'd1; tq = 16'd1; n = 16'd5; g = 16'd15;
        end
        1: begin
          si = 32'h7FFF_FFFF; sq = 32'h8000_0000;
          ti = 16'd1; tq = 16'hFFFF; n = 16'd2; g = 16'd1;
        end
        default: begin
          si = $urandom; sq = $urandom;
          ti = 16'($urandom); tq = 16'($urandom);
          n = 16'($urandom_range(1, 6)); g = 16'($urandom_range(0, 4));
        end
      endcase
      run_sweep(si, sq, ti, tq, n, g, 1'b0, 16'd0, -1, 400);
      p = period(g, 0);
      checks++;
      if (hung || pt_t.size() - p0 != int'(n)) begin
        errors++;
        $display("FAIL ramp_count r=%0d: got %0d pulses hung=%0b, need %0d",
                 r, pt_t.size() - p0, hung, n);
      end
      for (int k = 0; k < int'(n) && p0 + k < pt_t.size(); k++) begin
        checks++;
        if (pt_i[p0+k] !== ramp_at(si, ti, k) ||
            pt_q[p0+k] !== ramp_at(sq, tq, k)) begin
          errors++;
          $display("FAIL ramp_value r=%0d k=%0d: got %h/%h, need %h/%h", r, k,
                   pt_i[p0+k], pt_q[p0+k], ramp_at(si, ti, k), ramp_at(sq, tq, k));
        end
        checks++;
        if (pt_t[p0+k] != t0 + 1 + k * p) begin
          errors++;
          $display("FAIL ramp_time r=%0d k=%0d: got cycle %0d, need %0d",
                   r, k, pt_t[p0+k] - t0, 1 + k * p);
        end
      end
      checks++;
      if (done_t.size() != d0 + 1 || done_t[d0] != t0 + 1 + int'(n) * p) begin
        errors++;
        $display("FAIL ramp_done r=%0d: got %0d pulses, need 1 at cycle %0d",
                 r, done_t.size() - d0, 1 + int'(n) * p);
      end
      checks++;
      if (pts_sent !== n) begin
        errors++;
        $display("FAIL ramp_pts r=%0d: got %0d, need %0d", r, pts_sent, n);
      end
    end
    checks++;
    if (b2b != 0) begin
      errors++;
      $display("FAIL ramp_b2b: got %0d back-to-back strobes, need 0", b2b);
    end
  endtask

  task automatic test_ack;
    logic [31:0] si, sq;
    logic [15:0] ti, tq, n, g, tmo;
    int d, p;
    for (int r = 0; r < 4; r++) begin
      d  = (r == 0) ? 4 : $urandom_range(0, 5);
      g  = (r == 0) ? 16'd2 : 16'($urandom_range(0, 3));
      n  = (r == 0) ? 16'd4 : 16'($urandom_range(1, 5));
      tmo = (r == 0) ? 16'd0 : 16'(d + 2 + $urandom_range(0, 10));
      si = $urandom; sq = $urandom;
      ti = 16'($urandom); tq = 16'($urandom);
      run_sweep(si, sq, ti, tq, n, g, 1'b1, tmo, d, 400);
      p = period(g, d);
      checks++;
      if (hung || pt_t.size() - p0 != int'(n)) begin
        errors++;
        $display("FAIL ack_count r=%0d: got %0d pulses hung=%0b, need %0d",
                 r, pt_t.size() - p0, hung, n);
      end
      for (int k = 0; k < int'(n) && p0 + k < pt_t.size(); k++) begin
        checks++;
        if (pt_t[p0+k] != t0 + 1 + k * p ||
            pt_i[p0+k] !== ramp_at(si, ti, k) ||
            pt_q[p0+k] !== ramp_at(sq, tq, k)) begin
          errors++;
          $display("FAIL ack_point r=%0d k=%0d: got cyc %0d %h/%h, need cyc %0d %h/%h",
                   r, k, pt_t[p0+k] - t0, pt_i[p0+k], pt_q[p0+k],
                   1 + k * p, ramp_at(si, ti, k), ramp_at(sq, tq, k));
        end
      end
      checks++;
      if (done_t.size() != d0 + 1 || done_t[d0] != t0 + 1 + int'(n) * p) begin
        errors++;
        $display("FAIL ack_done r=%0d: got %0d pulses, need 1 at cycle %0d",
                 r, done_t.size() - d0, 1 + int'(n) * p);
      end
      checks++;
      if (timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL ack_timeout_err r=%0d: got %b, need 0", r, timeout_err);
      end
    end
  endtask

  task automatic test_timeout;
    int p;
    run_sweep(32'd10, 32'hFFFF_FFF0, 16'd3, 16'hFFFE, 16'd3, 16'd2,
              1'b1, 16'd10, -1, 400);
    p = period(16'd2, 10);
    checks++;
    if (hung || pt_t.size() - p0 != 3) begin
      errors++;
      $display("FAIL timeout_count: got %0d pulses hung=%0b, need 3",
               pt_t.size() - p0, hung);
    end
    for (int k = 0; k < 3 && p0 + k < pt_t.size(); k++) begin
      checks++;
      if (pt_t[p0+k] != t0 + 1 + k * p ||
          pt_i[p0+k] !== ramp_at(32'd10, 16'd3, k)) begin
        errors++;
        $display("FAIL timeout_point k=%0d: got cyc %0d i=%h, need cyc %0d i=%h",
                 k, pt_t[p0+k] - t0, pt_i[p0+k], 1 + k * p,
                 ramp_at(32'd10, 16'd3, k));
      end
    end
    checks++;
    if (timeout_err !== 1'b1 || pts_sent !== 16'd3) begin
      errors++;
      $display("FAIL timeout_status: got err=%b pts=%0d, need err=1 pts=3",
               timeout_err, pts_sent);
    end
    checks++;
    if (done_t.size() != d0 + 1) begin
      errors++;
      $display("FAIL timeout_done: got %0d done pulses, need 1",
               done_t.size() - d0);
    end
  endtask

  task automatic test_abort;
    @(negedge clk100);
    i_start = 32'd100; q_start = 32'd200; i_step = 16'd1; q_step = 16'd1;
    num_data_pts = 16'd6; gap_cycles = 16'd3;
    ack_mode = 1'b0; ack_timeout = 16'd0;
    p0 = pt_t.size(); d0 = done_t.size();
    start = 1'b1;
    @(negedge clk100);
    start = 1'b0;
    #1;
    checks++;
    if (timeout_err !== 1'b0 || pts_sent !== 16'd0) begin
      errors++;
      $display("FAIL abort_start_clear: got err=%b pts=%0d, need 0/0",
               timeout_err, pts_sent);
    end
    for (int c = 0; c < 100 && pt_t.size() - p0 < 2; c++) begin
      @(negedge clk100);
      #1;
    end
    checks++;
    if (pt_t.size() - p0 != 2) begin
      errors++;
      $display("FAIL abort_reach: got %0d pulses, need 2", pt_t.size() - p0);
    end
    @(negedge clk100);
    abort = 1'b1;
    @(negedge clk100);
    abort = 1'b0;
    repeat (60) @(negedge clk100);
    #1;
    checks++;
    if (pt_t.size() - p0 != 2 || done_t.size() != d0) begin
      errors++;
      $display("FAIL abort_stop: got %0d pulses %0d dones, need 2 and 0",
               pt_t.size() - p0, done_t.size() - d0);
    end
    checks++;
    if (busy !== 1'b0 || data_in !== 1'b0 || pts_sent !== 16'd2) begin
      errors++;
      $display("FAIL abort_status: got busy=%b din=%b pts=%0d, need 0 0 2",
               busy, data_in, pts_sent);
    end
    @(negedge clk100);
    start = 1'b1; abort = 1'b1;
    @(negedge clk100);
    start = 1'b0; abort = 1'b0;
    repeat (10) @(negedge clk100);
    #1;
    checks++;
    if (busy !== 1'b0 || pt_t.size() - p0 != 2 ||
        done_t.size() != d0 || pts_sent !== 16'd2) begin
      errors++;
      $display("FAIL start_abort: got busy=%b pulses=%0d dones=%0d pts=%0d, need 0 2 0 2",
               busy, pt_t.size() - p0, done_t.size() - d0, pts_sent);
    end
  endtask

  task automatic test_empty;
    run_sweep(32'd5, 32'd6, 16'd1, 16'd1, 16'd0, 16'd4, 1'b0, 16'd0, -1, 50);
    checks++;
    if (hung || done_t.size() != d0 + 1 || done_t[d0] != t0 + 1) begin
      errors++;
      $display("FAIL empty_done: got %0d dones hung=%0b, need 1 at cycle 1",
               done_t.size() - d0, hung);
    end
    checks++;
    if (busy !== 1'b1 || pts_sent !== 16'd0) begin
      errors++;
      $display("FAIL empty_busy: got busy=%b pts=%0d in done cycle, need 1 0",
               busy, pts_sent);
    end
    @(negedge clk100);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pt_t.size() != p0) begin
      errors++;
      $display("FAIL empty_after: got busy=%b done=%b pulses=%0d, need 0 0 0",
               busy, done, pt_t.size() - p0);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk100);
    i_start = 32'd1; q_start = 32'd2; i_step = 16'd5; q_step = 16'd7;
    num_data_pts = 16'd10; gap_cycles = 16'd3;
    ack_mode = 1'b0; ack_timeout = 16'd0;
    p0 = pt_t.size(); d0 = done_t.size();
    start = 1'b1;
    @(negedge clk100);
    start = 1'b0;
    #1;
    for (int c = 0; c < 100 && pt_t.size() - p0 < 2; c++) begin
      @(negedge clk100);
      #1;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk100);
    @(negedge clk100);
    checks++;
    if ({data_in, busy, done, timeout_err, pts_sent, i_val, q_val} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: din=%b busy=%b done=%b pts=%0d i=%h q=%h, need all 0",
               data_in, busy, done, pts_sent, i_val, q_val);
    end
    rst_n = 1'b1;
    repeat (60) @(negedge clk100);
    #1;
    checks++;
    if (pt_t.size() - p0 != 2 || done_t.size() != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: got pulses=%0d dones=%0d busy=%b, need 2 0 0",
               pt_t.size() - p0, done_t.size() - d0, busy);
    end
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_ack;
    test_timeout;
    test_abort;
    test_empty;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
